// File: rtl/ls_mem_responder_if.sv
// rtl/ls_mem_responder_if.sv - load/store request/response bundle between control unit and memory responder
interface ls_mem_responder_if;
    logic [1:0]  en_ls;
    logic [15:0] addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        ls_done;
    logic        busy;
    logic        ls_err;

    modport master (
        output en_ls, addr, wr_data,
        input  rd_data, ls_done, busy, ls_err
    );

    modport slave (
        input  en_ls, addr, wr_data,
        output rd_data, ls_done, busy, ls_err
    );
endinterface

// File: rtl/ls_mem_responder.sv
// rtl/ls_mem_responder.sv - memory-side load/store responder with 16-bit data memory
// Optional address-range check enabled by defining LS_ADDR_CHECK_EN.
module ls_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    ls_mem_responder_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_RELEASE} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                op_store_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wr_data_q;
    logic [15:0]         rd_data_q;
    logic                ls_done_q;
    logic                busy_q;
    logic                ls_err_q;

    logic [15:0]         mem [2**ADDR_W];

    logic                accept;
    logic                commit_busy;
    logic                commit;
    logic                commit_store;
    logic [ADDR_W-1:0]   commit_addr;
    logic [15:0]         commit_wdata;
    logic                req_oor;
    logic                commit_oor;

    assign accept      = (state_q == S_IDLE) && (bus.en_ls == 2'b01 || bus.en_ls == 2'b10);
    assign commit_busy = (state_q == S_BUSY) && (cnt_q == 4'd1);
    // With LATENCY=1 the accept edge is also the commit edge, so live inputs are used.
    assign commit       = commit_busy || (accept && LATENCY == 1);
    assign commit_store = commit_busy ? op_store_q : (bus.en_ls == 2'b10);
    assign commit_addr  = commit_busy ? addr_q     : bus.addr[ADDR_W-1:0];
    assign commit_wdata = commit_busy ? wr_data_q  : bus.wr_data;

`ifdef LS_ADDR_CHECK_EN
    logic oor_q;
    assign req_oor    = (bus.addr >> ADDR_W) != 16'd0;
    assign commit_oor = commit_busy ? oor_q : req_oor;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr;
    assign req_oor        = 1'b0;
    assign commit_oor     = 1'b0;
`endif

    // Memory contents survive reset; an access abandoned by reset never commits.
    always_ff @(posedge clk) begin
        if (!reset && commit && commit_store && !commit_oor) begin
            mem[commit_addr] <= commit_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            op_store_q <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= 16'h0000;
            rd_data_q  <= 16'h0000;
            ls_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            ls_err_q   <= 1'b0;
`ifdef LS_ADDR_CHECK_EN
            oor_q      <= 1'b0;
`endif
        end else begin
            ls_done_q <= 1'b0;
            ls_err_q  <= 1'b0;
            if (commit) begin
                ls_done_q <= 1'b1;
                ls_err_q  <= commit_oor;
                if (!commit_store) begin
                    rd_data_q <= commit_oor ? 16'hDEAD : mem[commit_addr];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_store_q <= (bus.en_ls == 2'b10);
                        addr_q     <= bus.addr[ADDR_W-1:0];
                        wr_data_q  <= bus.wr_data;
`ifdef LS_ADDR_CHECK_EN
                        oor_q      <= req_oor;
`endif
                        cnt_q      <= 4'(LATENCY - 1);
                        state_q    <= (LATENCY == 1) ? S_DONE : S_BUSY;
                        busy_q     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Hold off until the control unit withdraws its request.
                    if (bus.en_ls == 2'b00) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.ls_done = ls_done_q;
    assign bus.busy    = busy_q;
    assign bus.ls_err  = ls_err_q;
endmodule
